// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, datapath widths and the fetch packet.
package cpu_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned PC_STEP    = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

  // Instruction register payload: the word plus the address it came from.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_pkt_t;

  function automatic word_t align_pc(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_reg_if.sv
// Fetch-stage bus: instruction-memory port, redirect/consume control and decoded IR fields.
interface instr_fetch_reg_if;
  import cpu_pkg::*;

  logic                  imem_req;
  word_t                 imem_addr;
  logic                  imem_ack;
  word_t                 imem_rdata;
  logic                  redirect_valid;
  word_t                 redirect_pc;
  logic                  consume;
  logic                  instr_valid;
  word_t                 instr;
  word_t                 pc_out;
  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [IMM_W-1:0]      imm16;
  word_t                 fetch_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
           opcode, rs, rt, rd, imm16, fetch_count,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, consume
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
           opcode, rs, rt, rd, imm16, fetch_count,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, consume
  );

endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction fetch stage: PC, instruction register and fetch FSM with redirect priority.
// Optional capture counter enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_reg
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_reg_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  fetch_pkt_t   ir_q, ir_d;
  logic         req_q;
  logic         valid_q;
  logic         capture;

  // Next-state, PC and IR update; a redirect overrides anything the FSM decided.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_ack) begin
          ir_d.pc    = pc_q;
          ir_d.instr = bus.imem_rdata;
          pc_d       = pc_q + WORD_W'(PC_STEP);
          capture    = 1'b1;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.consume) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect_valid) begin
      state_d = S_WAIT;
      pc_d    = align_pc(bus.redirect_pc);
      ir_d    = ir_q;
      capture = 1'b0;
    end
  end

  // State, PC, IR and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= (state_d == S_WAIT);
      valid_q <= (state_d == S_VALID);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  word_t cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (capture) begin
      cnt_q <= cnt_q + WORD_W'(1);
    end
  end

  assign bus.fetch_count = cnt_q;
`else
  assign bus.fetch_count = '0;
`endif

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = ir_q.instr;
  assign bus.pc_out      = ir_q.pc;

  // Decoded fields are plain slices of the instruction register.
  assign bus.opcode = ir_q.instr[31:26];
  assign bus.rs     = ir_q.instr[25:21];
  assign bus.rt     = ir_q.instr[20:16];
  assign bus.rd     = ir_q.instr[15:11];
  assign bus.imm16  = ir_q.instr[15:0];

endmodule
